// File: rtl/unified_memory_arbiter_if.sv
// Pipeline-side and RAM-side signals of the unified memory arbiter.
// slave is the arbiter's view; master is the environment (pipeline stages + RAM).
interface unified_memory_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Shares one fixed-latency word RAM between the IF and MEM pipeline stages,
// one access in flight, with a bounded MEM run before IF is forced a grant.
module unified_memory_arbiter #(
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 10,
  parameter int MAX_MEM_RUN = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  unified_memory_arbiter_if.slave bus
);
  localparam int unsigned RUN_W = $clog2(MAX_MEM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_MEM_RUN);
  localparam logic [3:0]       LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_MEM, RESP} state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              acc_write;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;

  logic mem_pend;
  logic grant_mem;
  logic unused_addr_bits;

  assign mem_pend  = bus.mem_read | bus.mem_write;
  assign grant_mem = mem_pend & ~(bus.if_req & (run_cnt == RUN_MAX));

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      run_cnt     <= '0;
      acc_write   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state       <= WAIT_MEM;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.mem_write;
            acc_write   <= bus.mem_write;
            ram_addr_q  <= bus.mem_addr[ADDR_W+1:2];
            ram_wdata_q <= bus.mem_wdata;
            lat_cnt     <= LAT_INIT;
            if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
          end else if (bus.if_req) begin
            state       <= WAIT_IF;
            ram_en_q    <= 1'b1;
            acc_write   <= 1'b0;
            ram_addr_q  <= bus.if_addr[ADDR_W+1:2];
            ram_wdata_q <= '0;
            lat_cnt     <= LAT_INIT;
            run_cnt     <= '0;
          end else begin
            run_cnt <= '0;
          end
        end
        WAIT_IF: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == 4'd1) begin
            if_rdata_q <= bus.ram_rdata;
            if_ready_q <= 1'b1;
            state      <= RESP;
          end
        end
        WAIT_MEM: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == 4'd1) begin
            if (!acc_write) mem_rdata_q <= bus.ram_rdata;
            mem_ready_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          // Requests still high here are the ones being retired; IDLE re-evaluates next edge.
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  assign bus.stall_mem = mem_pend & ~mem_ready_q;
  assign bus.stall_if  = (bus.if_req & ~if_ready_q) | bus.stall_mem;
endmodule
